// File: rtl/icache_sa.sv
// rtl/icache_sa.sv - set-associative instruction cache with line refill and flush
//
// Purpose: read-only fetch cache. Requests are looked up one cycle after
// acceptance; hits answer in that cycle, misses refill a whole line from
// memory and answer once the line is installed. flush_req invalidates every
// line, one set per cycle.
//
// Ports:
//   clk_core    core clock, all state on the rising edge
//   reset_n     asynchronous active-low reset
//   rd_req      fetch request; accepted when rd_req & rd_ready
//   rd_addr     word address [28:2]: {tag, index, offset}
//   rd_ready    request can be accepted this cycle
//   rd_valid    one-cycle response strobe
//   rd_data     instruction word (qualified by rd_valid)
//   rd_hit      1 = served from array, 0 = served after refill
//   flush_req   invalidate-all request, level or pulse
//   flush_busy  high while invalidation runs
//   mem_req     line refill request, held until mem_ack
//   mem_addr    line-aligned refill word address
//   mem_ack     memory accepted the refill request
//   mem_rvalid  refill beat valid
//   mem_rdata   refill beat data

module icache_sa #(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk_core,
  input  logic        reset_n,
  input  logic        rd_req,
  input  logic [28:2] rd_addr,
  output logic        rd_ready,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        rd_hit,
  input  logic        flush_req,
  output logic        flush_busy,
  output logic        mem_req,
  output logic [28:2] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 27 - OFF_W - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL_REQ,
    S_REFILL_DATA,
    S_RESPOND,
    S_FLUSH
  } state_t;

  state_t state, state_nxt;

  // Request being served; also drives mem_addr so it is stable during refill.
  logic [28:2]      req_addr;
  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;

  assign {req_tag, req_idx, req_off} = req_addr;
  assign mem_addr = {req_tag, req_idx, {OFF_W{1'b0}}};

  // Valid bits need reset; tag and data arrays do not.
  logic [SETS-1:0]  valid    [WAYS];
  logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
  logic [31:0]      data_mem [WAYS][SETS][LINE_WORDS];

  logic [WAY_W-1:0] rr_ptr;
  logic [WAY_W-1:0] rr_next;
  logic [WAY_W-1:0] victim;
  logic [WAY_W-1:0] victim_way;
  logic             has_invalid;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [31:0]      hit_word;
  logic [OFF_W-1:0] beat_cnt;
  logic             last_beat;
  logic [31:0]      resp_word;
  logic [IDX_W-1:0] flush_cnt;
  logic             flush_last;
  logic             flush_pending;
  logic             accept;

  assign last_beat  = (beat_cnt == OFF_W'(LINE_WORDS - 1));
  assign flush_last = (flush_cnt == IDX_W'(SETS - 1));
  assign accept     = rd_req & rd_ready;
  assign rr_next    = (rr_ptr == WAY_W'(WAYS - 1)) ? '0 : rr_ptr + WAY_W'(1);

  // Tag compare across all ways of the addressed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[w][req_idx] && (tag_mem[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit_word = data_mem[hit_way][req_idx][req_off];

  // Victim: lowest-numbered invalid way (scan downward so the lowest wins),
  // otherwise the round-robin pointer.
  always_comb begin
    has_invalid = 1'b0;
    victim      = rr_ptr;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w][req_idx]) begin
        has_invalid = 1'b1;
        victim      = WAY_W'(w);
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (flush_req || flush_pending) begin
          state_nxt = S_FLUSH;
        end else if (rd_req) begin
          state_nxt = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (!hit) begin
          state_nxt = S_REFILL_REQ;
        end else if (!accept) begin
          state_nxt = S_IDLE;
        end
      end
      S_REFILL_REQ: begin
        if (mem_ack) begin
          state_nxt = S_REFILL_DATA;
        end
      end
      S_REFILL_DATA: begin
        if (mem_rvalid && last_beat) begin
          state_nxt = S_RESPOND;
        end
      end
      S_RESPOND: state_nxt = S_IDLE;
      S_FLUSH: begin
        if (flush_last) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    rd_ready   = 1'b0;
    rd_valid   = 1'b0;
    rd_hit     = 1'b0;
    rd_data    = '0;
    mem_req    = 1'b0;
    flush_busy = 1'b0;
    case (state)
      S_IDLE: rd_ready = !flush_pending && !flush_req;
      S_LOOKUP: begin
        if (hit) begin
          rd_valid = 1'b1;
          rd_hit   = 1'b1;
          rd_data  = hit_word;
          rd_ready = !flush_pending && !flush_req;
        end
      end
      S_REFILL_REQ: mem_req = 1'b1;
      S_RESPOND: begin
        rd_valid = 1'b1;
        rd_data  = resp_word;
      end
      S_FLUSH: flush_busy = 1'b1;
      default: ;
    endcase
  end

  // Control datapath: request capture, valid bits, replacement, counters.
  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      req_addr      <= '0;
      victim_way    <= '0;
      rr_ptr        <= '0;
      beat_cnt      <= '0;
      resp_word     <= '0;
      flush_cnt     <= '0;
      flush_pending <= 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        valid[w] <= '0;
      end
    end else begin
      if (accept) begin
        req_addr <= rd_addr;
      end

      // A flush arriving mid-transaction waits until the cache is idle.
      if (state == S_FLUSH && flush_last) begin
        flush_pending <= 1'b0;
      end else if (flush_req && state != S_IDLE && state != S_FLUSH) begin
        flush_pending <= 1'b1;
      end

      case (state)
        S_LOOKUP: begin
          if (!hit) begin
            // Invalidate the victim up front so an interrupted refill
            // never leaves a partially written line marked valid.
            victim_way              <= victim;
            valid[victim][req_idx]  <= 1'b0;
            beat_cnt                <= '0;
            if (!has_invalid) begin
              rr_ptr <= rr_next;
            end
          end
        end
        S_REFILL_DATA: begin
          if (mem_rvalid) begin
            beat_cnt <= beat_cnt + OFF_W'(1);
            if (beat_cnt == req_off) begin
              resp_word <= mem_rdata;
            end
            if (last_beat) begin
              valid[victim_way][req_idx] <= 1'b1;
            end
          end
        end
        S_FLUSH: begin
          for (int w = 0; w < WAYS; w++) begin
            valid[w][flush_cnt] <= 1'b0;
          end
          rr_ptr    <= '0;
          // Wraps back to zero on the last set, ready for the next flush.
          flush_cnt <= flush_cnt + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Array writes: refill beats land in the victim line in order; the tag is
  // written with the last beat, together with the valid bit.
  always_ff @(posedge clk_core) begin
    if (state == S_REFILL_DATA && mem_rvalid) begin
      data_mem[victim_way][req_idx][beat_cnt] <= mem_rdata;
      if (last_beat) begin
        tag_mem[victim_way][req_idx] <= req_tag;
      end
    end
  end

endmodule
